rot_tile_buffer: RTL and testbench

ROT_TILE_BUFFER -- requirements
Module: rot_tile_buffer

---
 rtl/rot_tile_buffer.sv | 229 ++++++++++++++++++++++
 tb/tb_rot_tile_buffer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rot_tile_buffer.sv
// -----------------------------------------------------------------------------
// rot_tile_buffer
//
// Collects a TILE x TILE block of pixels arriving in raster order, then emits
// the same block in raster order after rotating it clockwise by 0/90/180/270
// degrees. Rotation is selected by MODE and DIR, which are captured on the
// first pixel of every tile.
//
// Build option:
//   ROT_TILE_PINGPONG_EN  defined   -> two banks: the next tile loads while the
//                                      current one drains.
//                         undefined -> one bank: input stalls from FULL until
//                                      the cycle after the LAST output transfer.
//
// Ports:
//   I_HCLK            clock, everything on its rising edge
//   I_HRESET          asynchronous active-high reset
//   I_RTB_CLEAR       synchronous soft clear (wins over a simultaneous transfer)
//   I_RTB_MODE[1:0]   rotation 0/90/180/270 degrees
//   I_RTB_DIR         0 = clockwise, 1 = counter-clockwise
//   I_RTB_IN_VALID / O_RTB_IN_READY / I_RTB_IN_DATA       raster input stream
//   O_RTB_OUT_VALID / I_RTB_OUT_READY / O_RTB_OUT_DATA /
//   O_RTB_OUT_LAST                                        rotated output stream
//   O_RTB_TILE_DONE   one-cycle pulse after each LAST transfer
//   O_RTB_TILE_CNT    number of drained tiles, wraps at 16 bits
//   O_RTB_DBG_STATE   {bank1 state, bank0 state}; 0=EMPTY 1=LOAD 2=FULL 3=DRAIN
//
// Handshake: a beat moves on a rising edge where VALID and READY are both high.
// VALID never looks at READY; once VALID is up, DATA/LAST stay put until the
// beat moves. IN_READY may look at OUT_READY (two-bank build only).
// -----------------------------------------------------------------------------
module rot_tile_buffer #(
    parameter int TILE  = 4,
    parameter int PIX_W = 8
) (
    input  logic             I_HCLK,
    input  logic             I_HRESET,
    input  logic             I_RTB_CLEAR,
    input  logic [1:0]       I_RTB_MODE,
    input  logic             I_RTB_DIR,
    input  logic             I_RTB_IN_VALID,
    output logic             O_RTB_IN_READY,
    input  logic [PIX_W-1:0] I_RTB_IN_DATA,
    output logic             O_RTB_OUT_VALID,
    input  logic             I_RTB_OUT_READY,
    output logic [PIX_W-1:0] O_RTB_OUT_DATA,
    output logic             O_RTB_OUT_LAST,
    output logic             O_RTB_TILE_DONE,
    output logic [15:0]      O_RTB_TILE_CNT,
    output logic [3:0]       O_RTB_DBG_STATE
);

    localparam int LG = $clog2(TILE);
`ifdef ROT_TILE_PINGPONG_EN
    localparam bit PP = 1'b1;
    localparam int AW = 2 * LG + 1;
`else
    localparam bit PP = 1'b0;
    localparam int AW = 2 * LG;
`endif

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } bank_st_t;

    typedef logic [2*LG-1:0] pos_t;

    // Bank 1 only ever leaves EMPTY in the two-bank build.
    bank_st_t         st    [2];
    logic [1:0]       e_lat [2];   // latched effective clockwise quarter turns

    logic [PIX_W-1:0] mem [0:(1<<AW)-1];

    logic             wr_bank;
    logic [LG-1:0]    wr_r, wr_c;
    logic             rd_bank;     // bank of the tile currently being fetched/output
    logic [LG-1:0]    rd_r, rd_c;  // next output coordinate to fetch
    logic             rd_busy;     // fetches remain for the current tile

    logic             out_valid, out_last, tile_done;
    logic [PIX_W-1:0] out_data;
    logic [15:0]      tile_cnt;

    logic             last_fire, wr_free, in_fire, wr_end;
    logic             nxt_bank, adv, f_start, f_go, fb, f_end;
    logic [LG-1:0]    fr, fc, sr, sc;
    logic [1:0]       fe, e_in;
    pos_t             w_pos, f_pos;
    logic [AW-1:0]    waddr, raddr;

    assign last_fire = out_valid & I_RTB_OUT_READY & out_last;

    // In the two-bank build the writer may re-enter a draining bank on the
    // very edge its LAST pixel leaves: that pixel already sits in the output
    // register, so the storage is free. This keeps continuous input unstalled.
    assign wr_free = (st[wr_bank] == EMPTY) || (st[wr_bank] == LOAD) ||
                     (PP && (st[wr_bank] == DRAIN) && last_fire && (rd_bank == wr_bank));
    assign O_RTB_IN_READY = ~I_HRESET & wr_free;
    assign in_fire        = I_RTB_IN_VALID & O_RTB_IN_READY;
    assign wr_end         = (&wr_r) & (&wr_c);
    assign w_pos          = {wr_r, wr_c};

    // Counter-clockwise by k quarter turns equals clockwise by (4-k) mod 4.
    assign e_in = I_RTB_DIR ? 2'(2'd0 - I_RTB_MODE) : I_RTB_MODE;

    // The output register takes a new pixel whenever it is empty or its
    // current pixel moves this cycle; a new tile starts only once the previous
    // tile's fetches are done and the next bank in load order is FULL.
    assign nxt_bank = PP ? ~rd_bank : 1'b0;
    assign adv      = ~out_valid | I_RTB_OUT_READY;
    assign f_start  = adv & ~rd_busy & (st[nxt_bank] == FULL);
    assign f_go     = (adv & rd_busy) | f_start;
    assign fb       = rd_busy ? rd_bank : nxt_bank;
    assign fr       = rd_busy ? rd_r : '0;
    assign fc       = rd_busy ? rd_c : '0;
    assign fe       = e_lat[fb];
    assign f_end    = (&fr) & (&fc);
    assign f_pos    = {fr, fc};

    // Output (r,c) -> source pixel. With power-of-two tiles TILE-1-x is ~x.
    always_comb begin
        sr = fr;
        sc = fc;
        case (fe)
            2'd1:    begin sr = ~fc; sc = fr;  end
            2'd2:    begin sr = ~fr; sc = ~fc; end
            2'd3:    begin sr = fc;  sc = ~fr; end
            default: begin sr = fr;  sc = fc;  end
        endcase
    end

`ifdef ROT_TILE_PINGPONG_EN
    assign waddr = {wr_bank, wr_r, wr_c};
    assign raddr = {fb, sr, sc};
`else
    assign waddr = {wr_r, wr_c};
    assign raddr = {sr, sc};
`endif

    // Pixel storage: no reset, contents are don't-care until written.
    always_ff @(posedge I_HCLK) begin
        if (in_fire && !I_RTB_CLEAR) begin
            mem[waddr] <= I_RTB_IN_DATA;
        end
    end

    always_ff @(posedge I_HCLK or posedge I_HRESET) begin
        if (I_HRESET) begin
            for (int b = 0; b < 2; b++) begin
                st[b]    <= EMPTY;
                e_lat[b] <= 2'd0;
            end
            wr_bank   <= 1'b0;
            wr_r      <= '0;
            wr_c      <= '0;
            rd_bank   <= PP;
            rd_r      <= '0;
            rd_c      <= '0;
            rd_busy   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            tile_done <= 1'b0;
            tile_cnt  <= 16'd0;
        end else if (I_RTB_CLEAR) begin
            for (int b = 0; b < 2; b++) begin
                st[b]    <= EMPTY;
                e_lat[b] <= 2'd0;
            end
            wr_bank   <= 1'b0;
            wr_r      <= '0;
            wr_c      <= '0;
            rd_bank   <= PP;
            rd_r      <= '0;
            rd_c      <= '0;
            rd_busy   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            tile_done <= 1'b0;
            tile_cnt  <= 16'd0;
        end else begin
            tile_done <= last_fire;
            if (last_fire) begin
                tile_cnt     <= tile_cnt + 16'd1;
                st[rd_bank]  <= EMPTY;
            end

            if (f_go) begin
                out_data     <= mem[raddr];
                out_valid    <= 1'b1;
                out_last     <= f_end;
                rd_bank      <= fb;
                {rd_r, rd_c} <= f_pos + pos_t'(1);
                rd_busy      <= ~f_end;
                if (f_start) begin
                    st[fb] <= DRAIN;
                end
            end else if (adv) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            // Placed after the drain updates so a write into a bank whose
            // LAST leaves on the same edge lands it in LOAD, not EMPTY.
            if (in_fire) begin
                {wr_r, wr_c} <= w_pos + pos_t'(1);
                if (wr_end) begin
                    st[wr_bank] <= FULL;
                    wr_bank     <= PP ? ~wr_bank : 1'b0;
                end else if (st[wr_bank] != LOAD) begin
                    st[wr_bank]    <= LOAD;
                    e_lat[wr_bank] <= e_in;
                end
            end
        end
    end

    assign O_RTB_OUT_VALID = out_valid;
    assign O_RTB_OUT_DATA  = out_data;
    assign O_RTB_OUT_LAST  = out_last;
    assign O_RTB_TILE_DONE = tile_done;
    assign O_RTB_TILE_CNT  = tile_cnt;
    assign O_RTB_DBG_STATE = {st[1], st[0]};

endmodule

// File: tb/tb_rot_tile_buffer.sv
module tb_rot_tile_buffer;

  localparam int T       = 4;
  localparam int NPIX    = T * T;
  localparam int W       = 8;
  localparam int TIMEOUT = 200;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clr = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic         dir = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         tile_done;
  logic [15:0]  tile_cnt;
  logic [3:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int done_pulses = 0;
  int exp_done = 0;
  int in_stalls = 0;
  int out_gaps = 0;
  int out_pos = 0;

  logic [W-1:0] ramp   [NPIX];
  logic [W-1:0] fresh  [NPIX];
  logic [W-1:0] rnd_px [NPIX];
  logic [W-1:0] v_cw90  [NPIX] = '{12, 8, 4, 0, 13, 9, 5, 1, 14, 10, 6, 2, 15, 11, 7, 3};
  logic [W-1:0] v_ccw90 [NPIX] = '{3, 7, 11, 15, 2, 6, 10, 14, 1, 5, 9, 13, 0, 4, 8, 12};
  logic [W-1:0] v_180   [NPIX] = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
  logic [1:0]   rm;
  logic         rdr;

  rot_tile_buffer #(.TILE(T), .PIX_W(W)) dut (
    .I_HCLK          (clk),
    .I_HRESET        (rst),
    .I_RTB_CLEAR     (clr),
    .I_RTB_MODE      (mode),
    .I_RTB_DIR       (dir),
    .I_RTB_IN_VALID  (in_valid),
    .O_RTB_IN_READY  (in_ready),
    .I_RTB_IN_DATA   (in_data),
    .O_RTB_OUT_VALID (out_valid),
    .I_RTB_OUT_READY (out_ready),
    .O_RTB_OUT_DATA  (out_data),
    .O_RTB_OUT_LAST  (out_last),
    .O_RTB_TILE_DONE (tile_done),
    .O_RTB_TILE_CNT  (tile_cnt),
    .O_RTB_DBG_STATE (dbg_state)
  );

  // clock / pulse monitor
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tile_done === 1'b1) done_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: treat the tile as a 2-D picture and turn it clockwise
  // one quarter at a time; a quarter turn puts the old left column on top.
  function automatic void push_rotated(input logic [W-1:0] src[NPIX], input logic [1:0] m, input logic d);
    logic [W-1:0] a [T][T];
    logic [W-1:0] b [T][T];
    int turns;
    turns = d ? (4 - int'(m)) % 4 : int'(m);
    for (int r = 0; r < T; r++)
      for (int c = 0; c < T; c++)
        a[r][c] = src[r * T + c];
    repeat (turns) begin
      for (int r = 0; r < T; r++)
        for (int c = 0; c < T; c++)
          b[r][c] = a[T - 1 - c][r];
      a = b;
    end
    for (int r = 0; r < T; r++)
      for (int c = 0; c < T; c++)
        exp_q.push_back(a[r][c]);
  endfunction

  function automatic void push_literal(input logic [W-1:0] v[NPIX]);
    for (int i = 0; i < NPIX; i++) exp_q.push_back(v[i]);
  endfunction

  // Input driver: entered and left at posedge+1. After the first pixel MODE
  // and DIR are scrambled to show they were latched.
  task automatic send_pixels(input logic [W-1:0] px[NPIX], input int n, input logic [1:0] m,
                             input logic d, input int gap_pct);
    int wait_cyc;
    for (int i = 0; i < n; i++) begin
      while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = px[i];
      if (i == 0) begin
        mode = m;
        dir  = d;
      end else begin
        mode = 2'($urandom_range(3, 0));
        dir  = 1'($urandom_range(1, 0));
      end
      wait_cyc = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && wait_cyc < TIMEOUT) begin
        in_stalls++;
        wait_cyc++;
        @(negedge clk);
      end
      if (wait_cyc >= TIMEOUT) begin
        check("in_ready_timeout", in_ready, 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Output side: rmode 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
  task automatic recv_pixels(input int n, input int rmode);
    int got, cyc, phase, seen;
    logic [W-1:0] prev_d, e;
    logic prev_l, prev_stall;
    got = 0; cyc = 0; phase = 0; seen = 0; prev_stall = 1'b0;
    prev_d = '0; prev_l = 1'b0;
    out_gaps = 0;
    while (got < n && cyc < n * TIMEOUT) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (phase % 4 == 0) || (phase % 4 == 3);
        default: out_ready = 1'($urandom_range(1, 0));
      endcase
      phase++;
      @(negedge clk);
      if (prev_stall) begin
        check("hold_data", out_data, prev_d);
        check("hold_last", out_last, prev_l);
      end
      if (out_valid === 1'b1) seen = 1;
      else if (seen != 0) out_gaps++;
      if (out_valid === 1'b1 && out_ready) begin
        check("out_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", out_data, e);
        end
        check("out_last", out_last, out_pos == NPIX - 1);
        out_pos = (out_pos + 1) % NPIX;
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_l = out_last;
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    if (got < n) check("recv_timeout", got, n);
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) begin
      ramp[i]  = W'(i);
      fresh[i] = W'(100 + i);
    end

    // ---- reset ----
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_tile_done", tile_done, 0);
    check("rst_tile_cnt", tile_cnt, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // ---- 90 cw on ramp, output idle: latency and vector ----
    push_literal(v_cw90);
    send_pixels(ramp, NPIX, 2'd1, 1'b0, 0);
    @(negedge clk);
    check("lat_cycle1_valid", out_valid, 0);
`ifndef ROT_TILE_PINGPONG_EN
    check("full_in_ready_low", in_ready, 0);
`else
    check("pp_in_ready_high", in_ready, 1);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_cycle2_valid", out_valid, 1);
    check("first_pixel", out_data, 12);
    @(posedge clk); #1;
    recv_pixels(NPIX, 0);
    check("tile_done_pulse", tile_done, 1);
    check("cnt_after_1", tile_cnt, 1);
    check("no_bubbles", out_gaps, 0);
    exp_done++;
    @(posedge clk); #1;
    check("tile_done_once", done_pulses, exp_done);

    // ---- 90 ccw and 180 ----
    push_literal(v_ccw90);
    fork
      send_pixels(ramp, NPIX, 2'd1, 1'b1, 0);
      recv_pixels(NPIX, 0);
    join
    exp_done++;
    push_literal(v_180);
    fork
      send_pixels(ramp, NPIX, 2'd2, 1'b0, 0);
      recv_pixels(NPIX, 0);
    join
    exp_done++;
    @(posedge clk); #1;
    check("cnt_after_3", tile_cnt, 3);

    // ---- 0 deg with 1,0,0,1 output stall pattern ----
    push_rotated(ramp, 2'd0, 1'b0);
    fork
      send_pixels(ramp, NPIX, 2'd0, 1'b0, 0);
      recv_pixels(NPIX, 1);
    join
    exp_done++;
    @(posedge clk); #1;
    check("stall_q_empty", exp_q.size(), 0);
    check("done_after_stall", done_pulses, exp_done);

    // ---- clear while draining ----
    push_rotated(ramp, 2'd3, 1'b0);
    send_pixels(ramp, NPIX, 2'd3, 1'b0, 0);
    recv_pixels(3, 0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_out_valid", out_valid, 0);
    check("clr_cnt", tile_cnt, 0);
    check("clr_state", dbg_state, 0);
    exp_q.delete();
    out_pos = 0;

    // ---- clear after 7 pixels with a colliding transfer, then fresh tile ----
    send_pixels(ramp, 7, 2'd1, 1'b0, 0);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    @(posedge clk); #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr2_in_ready", in_ready, 1);
    check("clr2_state", dbg_state, 0);
    push_rotated(fresh, 2'd0, 1'b0);
    fork
      send_pixels(fresh, NPIX, 2'd0, 1'b0, 0);
      recv_pixels(NPIX, 0);
    join
    exp_done++;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("no_extra_output", out_valid, 0);
    out_ready = 1'b0;
    check("cnt_after_clear", tile_cnt, 1);

    // ---- randomized tiles, random gaps and output stalls ----
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          for (int i = 0; i < NPIX; i++) rnd_px[i] = W'($urandom);
          rm  = 2'($urandom_range(3, 0));
          rdr = 1'($urandom_range(1, 0));
          push_rotated(rnd_px, rm, rdr);
          send_pixels(rnd_px, NPIX, rm, rdr, 30);
        end
      end
      recv_pixels(6 * NPIX, 2);
    join
    exp_done += 6;
    @(posedge clk); #1;
    check("cnt_after_random", tile_cnt, 7);
    check("done_after_random", done_pulses, exp_done);

    // ---- three tiles back to back, output always ready ----
    in_stalls = 0;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          for (int i = 0; i < NPIX; i++) rnd_px[i] = W'($urandom);
          rm = 2'($urandom_range(3, 0));
          push_rotated(rnd_px, rm, 1'b0);
          send_pixels(rnd_px, NPIX, rm, 1'b0, 0);
        end
      end
      recv_pixels(3 * NPIX, 0);
    join
    exp_done += 3;
`ifdef ROT_TILE_PINGPONG_EN
    check("pp_in_stalls", in_stalls, 0);
    check("pp_out_gaps", out_gaps, 0);
`else
    check("single_in_stalls", in_stalls, 2 * 17);
`endif
    @(posedge clk); #1;
    check("cnt_after_stream", tile_cnt, 10);

    // ---- reset in the middle of a drain ----
    push_rotated(ramp, 2'd2, 1'b1);
    send_pixels(ramp, NPIX, 2'd2, 1'b1, 0);
    recv_pixels(5, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_cnt", tile_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    out_pos = 0;
    @(negedge clk);
    check("mid_rst_release_ready", in_ready, 1);
    check("mid_rst_release_cnt", tile_cnt, 0);
    @(posedge clk); #1;
    push_rotated(fresh, 2'd3, 1'b0);
    fork
      send_pixels(fresh, NPIX, 2'd3, 1'b0, 0);
      recv_pixels(NPIX, 2);
    join
    exp_done++;
    @(posedge clk); #1;
    check("cnt_after_recovery", tile_cnt, 1);
    check("final_q_empty", exp_q.size(), 0);
    check("final_done_pulses", done_pulses, exp_done);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
